// File: rtl/pmod_host.sv
// Host end of the 2-bit PMOD link: serializes read/write commands onto pck/pwrite/pwd,
// paces frames with the device's pwait and deserializes read data from prd.
module pmod_host #(
  parameter int CK_DIV  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_len,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_nbytes,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        pck,
  output logic        pwrite,
  output logic [1:0]  pwd,
  input  logic [1:0]  prd,
  input  logic        pwait,
  output logic [3:0]  o_dbg_state
);

  localparam int WAIT_CLKS = TIMEOUT * 2 * CK_DIV;
  localparam int WW        = $clog2(WAIT_CLKS + 1);
  localparam int SW        = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam int DW        = $clog2(CK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_WAITRDY, S_LEN, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_GAP, S_DONE
  } state_t;

  // Command handshake: a command is taken on any cycle with cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so it falls the cycle after accept and
  // returns the cycle after the single-cycle rsp_valid pulse.
  state_t          r_state;
  state_t          w_state_n;
  logic            r_pwait_meta;
  logic            r_pwait_s;
  logic [DW-1:0]   r_div;
  logic [SW-1:0]   r_slot;
  logic [SW-1:0]   w_slot_n;
  logic [SW-1:0]   w_nslots_m1;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_pck;
  logic            r_pwrite;
  logic [1:0]      r_pwd;
  logic [1:0]      w_pwd_n;
  logic            r_write;
  logic [9:0]      r_len;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [4:0]      r_nslots;
  logic [4:0]      w_nslots_cmd;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     w_pwd_src;
  logic            w_accept;
  logic            w_frame;
  logic            w_last_div;
  logic            w_slot_end;
  logic            w_sample;
  logic            w_start_slot;
  logic            w_set_err;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_frame      = (r_state == S_LEN)   || (r_state == S_ADDR)  || (r_state == S_WDATA) ||
                        (r_state == S_RWAIT) || (r_state == S_RDATA) || (r_state == S_GAP);
  assign w_last_div   = (r_div == DW'(CK_DIV - 1));
  assign w_slot_end   = w_frame && !r_pck && w_last_div;
  assign w_sample     = w_frame && r_pck && w_last_div;
  assign w_nslots_m1  = SW'(r_nslots) - SW'(1);
  assign w_nslots_cmd = ((cmd_nbytes == 3'd0) || (cmd_nbytes > 3'd4)) ? 5'd16 : {cmd_nbytes, 2'b00};

  always_comb begin
    w_state_n    = r_state;
    w_slot_n     = r_slot;
    w_start_slot = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_n = S_WAITRDY;
      S_WAITRDY: begin
        if (!r_pwait_s) begin
          w_state_n    = S_LEN;
          w_start_slot = 1'b1;
          w_slot_n     = '0;
        end else if (r_wait_cnt == WW'(WAIT_CLKS - 1)) begin
          w_state_n = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_LEN:   if (w_slot_end && (r_slot == SW'(4)))  w_state_n = S_ADDR;
      S_ADDR:  if (w_slot_end && (r_slot == SW'(15))) w_state_n = r_write ? S_WDATA : S_RWAIT;
      S_WDATA: if (w_slot_end && (r_slot == w_nslots_m1)) w_state_n = S_GAP;
      S_RWAIT: begin
        // pwait is only honoured here and in WAITRDY, at slot boundaries
        if (w_slot_end) begin
          if (!r_pwait_s) begin
            w_state_n = S_RDATA;
          end else if (r_slot == SW'(TIMEOUT - 1)) begin
            w_state_n = S_GAP;
            w_set_err = 1'b1;
          end
        end
      end
      S_RDATA: if (w_slot_end && (r_slot == w_nslots_m1)) w_state_n = S_GAP;
      S_GAP:   if (w_slot_end && (r_slot == SW'(3))) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (w_slot_end && (w_state_n != S_DONE)) begin
      w_start_slot = 1'b1;
      w_slot_n     = (w_state_n == r_state) ? r_slot + SW'(1) : '0;
    end
    w_pwd_src = 32'd0;
    case (w_state_n)
      S_LEN:   w_pwd_src = {22'd0, r_len};
      S_ADDR:  w_pwd_src = r_addr;
      S_WDATA: w_pwd_src = r_wdata;
      default: w_pwd_src = 32'd0;
    endcase
    w_pwd_n = w_pwd_src[{w_slot_n[3:0], 1'b0} +: 2];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_pwait_meta <= 1'b0;
      r_pwait_s    <= 1'b0;
      r_div        <= '0;
      r_slot       <= '0;
      r_wait_cnt   <= '0;
      r_pck        <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwd        <= 2'b00;
      r_write      <= 1'b0;
      r_len        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_nslots     <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pwait_meta <= pwait;
      r_pwait_s    <= r_pwait_meta;
      r_wait_cnt   <= (r_state == S_WAITRDY) ? r_wait_cnt + WW'(1) : '0;
      if (w_accept) begin
        r_write  <= cmd_write;
        r_len    <= cmd_len;
        r_addr   <= cmd_addr;
        r_wdata  <= cmd_wdata;
        r_nslots <= w_nslots_cmd;
        r_rdata  <= '0;
        r_err    <= 1'b0;
      end
      if (w_set_err) r_err <= 1'b1;
      // New slot: pck rises together with the slot's pwd/pwrite
      if (w_start_slot) begin
        r_pck    <= 1'b1;
        r_div    <= '0;
        r_slot   <= w_slot_n;
        r_pwd    <= w_pwd_n;
        r_pwrite <= r_write;
      end else if (w_frame) begin
        if (w_last_div) begin
          r_div <= '0;
          r_pck <= 1'b0;
          if (!r_pck) begin
            r_pwrite <= 1'b0;
            r_pwd    <= 2'b00;
          end
        end else begin
          r_div <= r_div + DW'(1);
        end
      end
      if (w_sample && (r_state == S_RDATA)) r_rdata[{r_slot[3:0], 1'b0} +: 2] <= prd;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_DONE);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign pck         = r_pck;
  assign pwrite      = r_pwrite;
  assign pwd         = r_pwd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pmod_host.sv
// Directed bench for pmod_host: device-side model on prd/pwait, pwd slot scoreboard
// and response scoreboard; a second instance with a short TIMEOUT covers the abort path.
module tb_pmod_host;

  localparam int CK_DIV = 3;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_write;
  logic [9:0]  cmd_len;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_nbytes;
  logic [31:0] cmd_wdata;
  logic [1:0]  prd;
  logic        pwait;
  logic        sel_to;

  logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_pck, a_pwrite;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_pwd;
  logic [3:0]  a_dbg;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_pck, b_pwrite;
  logic [31:0] b_rsp_rdata;
  logic [1:0]  b_pwd;
  logic [3:0]  b_dbg;
  logic        a_cmd_valid, b_cmd_valid;

  logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_pck, m_pwrite;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  m_pwd;

  assign a_cmd_valid = cmd_valid && !sel_to;
  assign b_cmd_valid = cmd_valid && sel_to;
  assign m_cmd_ready = sel_to ? b_cmd_ready : a_cmd_ready;
  assign m_rsp_valid = sel_to ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = sel_to ? b_rsp_err   : a_rsp_err;
  assign m_rsp_rdata = sel_to ? b_rsp_rdata : a_rsp_rdata;
  assign m_pck       = sel_to ? b_pck       : a_pck;
  assign m_pwrite    = sel_to ? b_pwrite    : a_pwrite;
  assign m_pwd       = sel_to ? b_pwd       : a_pwd;

  pmod_host #(.CK_DIV(CK_DIV), .TIMEOUT(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_write(cmd_write), .cmd_len(cmd_len), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .cmd_wdata(cmd_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .pck(a_pck), .pwrite(a_pwrite), .pwd(a_pwd), .prd(prd), .pwait(pwait), .o_dbg_state(a_dbg)
  );

  pmod_host #(.CK_DIV(CK_DIV), .TIMEOUT(8)) dut_to (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(cmd_write), .cmd_len(cmd_len), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .cmd_wdata(cmd_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .pck(b_pck), .pwrite(b_pwrite), .pwd(b_pwd), .prd(prd), .pwait(pwait), .o_dbg_state(b_dbg)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // scoreboard state
  logic [1:0]  exp_q[$];
  logic [32:0] exp_rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_cnt = 0;
  int          first_rise_cyc = 0;
  int          last_rsp_cyc = -1;
  int          rsp_cnt = 0;
  int          exp_rises = 0;
  logic        exp_pwrite = 1'b0;
  logic        strict = 1'b0;
  logic        prev_pck = 1'b0;

  // device model state
  logic        dev_read = 1'b0;
  logic        dev_forever = 1'b0;
  int          dev_phase = 0;
  int          dev_hold = 0;
  int          dev_k = 0;
  int          dev_nslots = 0;
  logic [31:0] dev_data = '0;

  string       hello = "hello, world\r\n";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=none expected=event", tag);
  endtask

  task automatic device_on_rise();
    if (dev_read) begin
      if (rise_cnt == 21) begin
        pwait = 1'b1;
      end else if (rise_cnt > 21) begin
        if (dev_phase == 0) begin
          if (!dev_forever && (rise_cnt - 21 == dev_hold + 1)) begin
            pwait     = 1'b0;
            dev_phase = 1;
          end
        end else if (dev_phase == 1) begin
          prd = dev_data[2*dev_k +: 2];
          dev_k++;
          if (dev_k == dev_nslots) dev_phase = 2;
        end else begin
          prd = 2'b00;
        end
      end
    end
  endtask

  // one clock: sample at the falling edge, run monitor and device model
  task automatic tick();
    logic [1:0]  e;
    logic [32:0] er;
    @(negedge ACLK);
    cyc++;
    if (m_pck && !prev_pck) begin
      rise_cnt++;
      if (rise_cnt == 1) begin
        first_rise_cyc = cyc;
        if (last_rsp_cyc >= 0) check("rsp_to_rise_ge2", 64'(cyc - last_rsp_cyc >= 2), 64'd1);
      end
      check("pwrite", 64'(m_pwrite), 64'(exp_pwrite));
      check("busy_ready", 64'(m_cmd_ready), 64'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwd", 64'(m_pwd), 64'(e));
      end else if (strict) begin
        fail("pwd_extra_slot");
      end
      device_on_rise();
    end
    prev_pck = m_pck;
    if (m_rsp_valid) begin
      if (exp_rsp_q.size() == 0) begin
        fail("rsp_unexpected");
      end else begin
        er = exp_rsp_q.pop_front();
        check("rsp_rdata", 64'(m_rsp_rdata), 64'(er[31:0]));
        check("rsp_err", 64'(m_rsp_err), 64'(er[32]));
        check("frame_slots", 64'(rise_cnt), 64'(exp_rises));
        check("frame_clocks", 64'(cyc - first_rise_cyc), 64'(exp_rises * 2 * CK_DIV));
        if (strict) check("pwd_missing", 64'(exp_q.size()), 64'd0);
      end
      rsp_cnt++;
      last_rsp_cyc = cyc;
      rise_cnt = 0;
    end
  endtask

  // driver: present a command, push expectations when it is accepted
  task automatic send(input logic w, input logic [9:0] len, input logic [31:0] addr,
                      input logic [2:0] nb, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input int n_rw, input logic keep);
    int n;
    int nsl;
    cmd_write  = w;
    cmd_len    = len;
    cmd_addr   = addr;
    cmd_nbytes = nb;
    cmd_wdata  = wd;
    cmd_valid  = 1'b1;
    n = 0;
    while (!m_cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!m_cmd_ready) fail("accept_timeout");
    nsl = ((nb == 3'd0) || (nb > 3'd4)) ? 16 : 4 * int'(nb);
    for (int k = 0; k < 5; k++)  exp_q.push_back(len[2*k +: 2]);
    for (int k = 0; k < 16; k++) exp_q.push_back(addr[2*k +: 2]);
    if (w) begin
      for (int k = 0; k < nsl; k++) exp_q.push_back(wd[2*k +: 2]);
      for (int k = 0; k < 4; k++)   exp_q.push_back(2'b00);
      exp_rises = 25 + nsl;
      strict    = 1'b1;
    end else begin
      for (int k = 0; k < n_rw; k++) exp_q.push_back(2'b00);
      exp_rises = 21 + n_rw + (exp_err ? 0 : nsl) + 4;
      strict    = 1'b0;
    end
    exp_pwrite = w;
    exp_rsp_q.push_back({exp_err, exp_rd});
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int limit);
    int n;
    n = 0;
    while (rsp_cnt < target && n < limit) begin
      tick();
      n++;
    end
    if (rsp_cnt < target) fail("rsp_timeout");
  endtask

  task automatic setup_read(input int hold, input logic forever_busy, input int nsl,
                            input logic [31:0] data);
    dev_read    = 1'b1;
    dev_forever = forever_busy;
    dev_phase   = 0;
    dev_hold    = hold;
    dev_k       = 0;
    dev_nslots  = nsl;
    dev_data    = data;
  endtask

  initial begin
    int          base;
    int          drop_cyc;
    logic [31:0] rnd;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = '0; cmd_addr = '0;
    cmd_nbytes = '0; cmd_wdata = '0; prd = 2'b00; pwait = 1'b0; sel_to = 1'b0;
    repeat (3) tick();
    check("rst_pck", 64'(m_pck), 64'd0);
    check("rst_pwrite", 64'(m_pwrite), 64'd0);
    check("rst_pwd", 64'(m_pwd), 64'd0);
    check("rst_cmd_ready", 64'(m_cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(m_rsp_err), 64'd0);
    ARESET = 1'b0;
    repeat (3) tick();

    // single-byte write
    send(1'b1, 10'd2, 32'h4060_0004, 3'd1, 32'h68, 32'd0, 1'b0, 0, 1'b0);
    wait_rsp(1, 400);

    // 4-byte read, device busy for 10 slots after ADDR
    setup_read(10, 1'b0, 16, 32'hDEAD_BEEF);
    send(1'b0, 10'd4, 32'h4000_0000, 3'd4, 32'd0, 32'hDEAD_BEEF, 1'b0, 11, 1'b0);
    wait_rsp(2, 800);
    dev_read = 1'b0; prd = 2'b00; pwait = 1'b0;
    repeat (4) tick();

    // 2-byte read: upper bytes must stay zero
    rnd = $urandom;
    setup_read(0, 1'b0, 8, rnd);
    send(1'b0, 10'd1, 32'h1000_0010, 3'd2, 32'd0, {16'd0, rnd[15:0]}, 1'b0, 1, 1'b0);
    wait_rsp(3, 600);
    dev_read = 1'b0; prd = 2'b00; pwait = 1'b0;
    repeat (4) tick();

    // RWAIT timeout on the short-timeout instance
    sel_to = 1'b1;
    setup_read(0, 1'b1, 16, 32'hFFFF_FFFF);
    send(1'b0, 10'd3, 32'h0000_1234, 3'd2, 32'd0, 32'd0, 1'b1, 8, 1'b0);
    wait_rsp(4, 600);
    dev_read = 1'b0; prd = 2'b00; pwait = 1'b0;
    repeat (4) tick();
    sel_to = 1'b0;
    repeat (2) tick();

    // nbytes 0 and 6 both move four bytes
    send(1'b1, 10'd3, $urandom, 3'd0, $urandom, 32'd0, 1'b0, 0, 1'b0);
    wait_rsp(5, 600);
    send(1'b1, 10'h3FF, 32'hFFFF_FFFF, 3'd6, $urandom, 32'd0, 1'b0, 0, 1'b0);
    wait_rsp(6, 600);

    // back-to-back stream with cmd_valid held high
    base = rsp_cnt;
    for (int i = 0; i < 14; i++)
      send(1'b1, 10'(i), 32'h4060_0000, 3'd1, {24'd0, hello[i]}, 32'd0, 1'b0, 0, 1'b1);
    cmd_valid = 1'b0;
    wait_rsp(base + 14, 1000);
    check("hello_rsp_count", 64'(rsp_cnt - base), 64'd14);

    // reset during ADDR slot 7
    send(1'b1, 10'd5, 32'hA5A5_5A5A, 3'd2, 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (rise_cnt < 13 && n < 200) begin
        tick();
        n++;
      end
      if (rise_cnt < 13) fail("reach_addr7");
    end
    ARESET = 1'b1;
    tick();
    check("abort_pck", 64'(m_pck), 64'd0);
    check("abort_pwd", 64'(m_pwd), 64'd0);
    check("abort_pwrite", 64'(m_pwrite), 64'd0);
    check("abort_cmd_ready", 64'(m_cmd_ready), 64'd1);
    check("abort_rsp_valid", 64'(m_rsp_valid), 64'd0);
    ARESET = 1'b0;
    exp_q.delete();
    exp_rsp_q.delete();
    rise_cnt = 0;
    base = rsp_cnt;
    repeat (100) tick();
    check("abort_no_rsp", 64'(rsp_cnt - base), 64'd0);
    send(1'b1, 10'd7, 32'h0BAD_F00D, 3'd3, 32'h00C0_FFEE, 32'd0, 1'b0, 0, 1'b0);
    wait_rsp(base + 1, 600);

    // start gating: device busy at accept
    pwait = 1'b1;
    repeat (4) tick();
    base = rsp_cnt;
    send(1'b1, 10'd1, 32'h0000_0040, 3'd1, 32'h5A, 32'd0, 1'b0, 0, 1'b0);
    repeat (30) tick();
    check("gate_no_pck", 64'(rise_cnt), 64'd0);
    pwait = 1'b0;
    drop_cyc = cyc;
    wait_rsp(base + 1, 600);
    check("gate_first_rise", 64'(first_rise_cyc - drop_cyc), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmod_host.md
Name: pmod_host

Overview:
- Host-side master of the 2-bit PMOD link. It is the opposite end of pmodIf, and it serializes AXI-style read and write commands onto pck/pwrite/pwd.
- It generates pck, paces transfers using pwait, and deserializes read data from prd.
- It sits in the FPGA-side test/bring-up harness and in the emulated-Pico model, where it drives pmodIf exactly as the Pico firmware does.

Parameters:
- CK_DIV, 3: system clocks per pck half-period (≥2).
- TIMEOUT, 1024: max pck slots spent waiting for pwait low before aborting.

Ports:
- ACLK  in  1  system clock
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_len  in  10  LEN field, sent verbatim
- cmd_addr  in  32  address field
- cmd_nbytes  in  3  data bytes to move, 1..4 (0 or >4 treated as 4)
- cmd_wdata  in  32  write data, byte 0 first
- rsp_valid  out  1  one-cycle pulse at frame end
- rsp_rdata  out  32  read data, valid with rsp_valid (zero for writes)
- rsp_err  out  1  pwait timeout, valid with rsp_valid
- pck  out  1  PMOD clock
- pwrite  out  1  frame direction
- pwd  out  2  host→device data
- prd  in  2  device→host data
- pwait  in  1  device busy, asynchronous

Behaviour:
- Reset values:
  - pck=0, pwrite=0, pwd=0.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State=IDLE, all counters 0.
- pwait handling:
  - pwait passes through a 2-flop synchronizer; only pwait_s is used.
  - prd is sampled directly; it is stable by construction at the sample point.
- Slot timing:
  - A slot is one pck period: CK_DIV clocks high, then CK_DIV clocks low.
  - pck is held low outside frames.
  - Host updates pwd/pwrite in the same ACLK cycle that pck rises.
  - Device samples pwd on pck fall; host samples prd on the last ACLK cycle of the high phase, i.e. the cycle before pck falls.
- Accept:
  - A command is accepted when cmd_valid && cmd_ready.
  - All cmd_* fields are latched; cmd_ready drops the next cycle and stays low until the cycle after rsp_valid.
- State machine (slot counter per state, all fields LSB first, 2 bits/slot):
  - IDLE → WAITRDY on accept.
  - WAITRDY: pck idle. Go to LEN when pwait_s=0; otherwise count TIMEOUT×2×CK_DIV clocks, then go to DONE with err=1.
  - LEN: 5 slots, cmd_len[2k+1:2k]. pwrite=cmd_write for the whole frame.
  - ADDR: 16 slots, cmd_addr.
  - Write path: WDATA for 4×nbytes slots of cmd_wdata, then GAP.
  - Read path: RWAIT.
    - pck keeps toggling and pwd=0.
    - Leave RWAIT on the first slot boundary with pwait_s=0, then go to RDATA.
    - Timeout after TIMEOUT slots, then go to GAP with err=1.
  - RDATA: 4×nbytes slots; prd goes into rdata[2k+1:2k]; unused upper bytes are 0.
  - GAP: 4 slots with pwd=0.
  - DONE: pck low, pwrite=0. rsp_valid=1 for 1 cycle, then IDLE.
- Latency:
  - Write frame: (25+4n) slots.
  - rsp_valid comes 1 clock after the final GAP slot ends.
- Boundary conditions:
  - pwait_s rising mid-LEN/ADDR/WDATA is ignored; it is only checked in WAITRDY and RWAIT.
  - cmd_valid while busy is not accepted; there is no queue.
  - Back-to-back commands: the next frame's first pck rise is no earlier than 2 clocks after rsp_valid.
  - ARESET mid-frame: abort immediately, outputs return to reset values next clock, and no rsp_valid is produced.
  - nbytes=0 → 4.

Test Plan:
- Write, CK_DIV=3: cmd_write=1, len=2, addr=0x4060_0004, nbytes=1, wdata=0x68, pwait=0.
  - pwd slots: LEN 2,0,0,0,0; ADDR 0,1,0,0, 0,0,0,0, 0,0,2,1, 0,0,0,1; DATA 0,2,2,1; GAP 0,0,0,0.
  - pwrite=1 throughout; rsp_valid after 29 slots (174 clocks), rsp_err=0.
- Read: len=4, addr=0x4000_0000, nbytes=4; pwait high for 10 slots after ADDR; device drives 0xDEADBEEF LSB-first on prd.
  - Required: rsp_rdata=0xDEADBEEF, rsp_err=0, pwrite=0 all frame.
- Timeout: read with pwait held high, TIMEOUT=8 → rsp_valid after exactly 8 RWAIT slots + GAP, rsp_err=1, rsp_rdata=0.
- "hello, world\r\n" stream: 14 back-to-back 1-byte writes with cmd_valid held high → each frame correct, cmd_ready low throughout each frame, 14 rsp_valid pulses.
- Reset mid-ADDR (slot 7) → next clock pck=0, pwd=0, pwrite=0, cmd_ready=1, no rsp_valid; the following write completes normally.
- Start gating: pwait high at accept for 5 slots → no pck edge until 2 clocks after pwait falls (synchronizer), then LEN begins.
